// File: rtl/dsm_modulator_tx.sv
// dsm_modulator_tx
//   Second-order digital delta-sigma modulator. Signed PCM samples arrive
//   over a valid/ready handshake, are parked in a one-entry holding buffer,
//   and are promoted to the active sample at every frame boundary (once every
//   OSR clocks). The two integrators run every clock and produce a registered
//   1-bit stream whose long-run ones density is (act/FS + 1)/2.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   in_data      signed PCM sample, WIDTH bits
//   in_valid     sample offered
//   in_ready     block can accept a sample this cycle
//   bit_out      registered modulator bitstream
//   frame_start  high while the frame counter is 0
//   underrun     one-cycle pulse: frame boundary reached with an empty buffer
module dsm_modulator_tx #(
    parameter int WIDTH = 16,
    parameter int OSR   = 64,
    parameter int ACC_W = WIDTH + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    bit_out,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int CNT_W = $clog2(OSR);
    localparam int SUM_W = ACC_W + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    localparam logic signed [SUM_W-1:0] FS      = {{(SUM_W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};

    // Clamp a wide intermediate sum back into the integrator range so the
    // integrators pin at the rails instead of wrapping through zero.
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[ACC_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[ACC_W-1:0];
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [WIDTH-1:0] buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic signed [WIDTH-1:0] act_q, act_d;
    logic signed [ACC_W-1:0] int1_q, int1_d;
    logic signed [ACC_W-1:0] int2_q, int2_d;
    logic                    bit_q, bit_d;

    logic                    boundary;
    logic                    accept;
    logic signed [SUM_W-1:0] fb, int1_x, int2_x, act_x, n1, n2;

    assign boundary    = (cnt_q == CNT_LAST);
    // The boundary frees the buffer in the same cycle, so a full buffer can
    // still take a sample there.
    assign in_ready    = ~buf_full_q | boundary;
    assign accept      = in_valid & in_ready;
    assign frame_start = (cnt_q == '0);
    assign underrun    = boundary & ~buf_full_q;
    assign bit_out     = bit_q;

    always_comb begin
        cnt_d      = boundary ? '0 : cnt_q + CNT_W'(1);
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        act_d      = act_q;

        if (boundary) begin
            // With an empty buffer the active sample simply holds; a late
            // accept in this cycle is parked for the next frame.
            if (buf_full_q) begin
                act_d = buf_q;
            end
            buf_full_d = accept;
        end else if (accept) begin
            buf_full_d = 1'b1;
        end
        if (accept) begin
            buf_d = in_data;
        end

        int1_x = {{(SUM_W-ACC_W){int1_q[ACC_W-1]}}, int1_q};
        int2_x = {{(SUM_W-ACC_W){int2_q[ACC_W-1]}}, int2_q};
        act_x  = {{(SUM_W-WIDTH){act_q[WIDTH-1]}}, act_q};
        fb     = bit_q ? FS : -FS;

        // Second integrator sees the pre-update value of the first.
        n1     = int1_x + act_x - fb;
        n2     = int2_x + int1_x - fb;
        int1_d = sat(n1);
        int2_d = sat(n2);
        bit_d  = ~int2_d[ACC_W-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            act_q      <= '0;
            int1_q     <= '0;
            int2_q     <= '0;
            bit_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            act_q      <= act_d;
            int1_q     <= int1_d;
            int2_q     <= int2_d;
            bit_q      <= bit_d;
        end
    end

endmodule
